// File: rtl/spike_edge_array_if.sv
// spike_edge_array_if: 8-bit peripheral register bus.
// master drives address/data_write/data_in, slave returns data_out.
interface spike_edge_array_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output address,
    output data_write,
    output data_in,
    input  data_out
  );

  modport slave (
    input  address,
    input  data_write,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/spike_edge_array.sv
// spike_edge_array: multi-channel pixel temporal-edge spike detector
// with per-channel threshold, saturating count, refractory timer and
// a shared event FIFO drained over the register bus.
// Ports: clk, rst (async, active-high), ui_in (reserved),
//   uo_out {2'b0, overflow, fifo nonempty, spike[3:0]},
//   bus (slave): address, data_write, data_in, data_out (comb read).
// Option: define SPIKE_TIMESTAMP_EN to tag FIFO entries with a
//   free-running 6-bit timestamp in bits [7:2].
module spike_edge_array #(
  parameter int CHANNELS       = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REFRAC_DEFAULT = 3,
  parameter int THRESH_DEFAULT = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ui_in,
  output logic [7:0]        uo_out,
  spike_edge_array_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic unused_ui;
  assign unused_ui = ^ui_in;

  // ---------------- bus decode ----------------
  logic [1:0] fn;
  logic [1:0] ch;
  logic [CHANNELS-1:0] ch_sel;
  logic wr_pix, wr_thr, wr_cnt;
  logic wr_pop, wr_ref, wr_ctl;

  assign fn = bus.address[3:2];
  assign ch = bus.address[1:0];

  always_comb begin
    ch_sel = '0;
    for (int c = 0; c < CHANNELS; c++)
      ch_sel[c] = (ch == 2'(c));
  end

  always_comb begin
    wr_pix = 1'b0;
    wr_thr = 1'b0;
    wr_cnt = 1'b0;
    wr_pop = 1'b0;
    wr_ref = 1'b0;
    wr_ctl = 1'b0;
    if (bus.data_write) begin
      unique case (1'b1)
        fn == 2'd0:           wr_pix = 1'b1;
        fn == 2'd1:           wr_thr = 1'b1;
        fn == 2'd2:           wr_cnt = 1'b1;
        bus.address == 4'hC:  wr_pop = 1'b1;
        bus.address == 4'hE:  wr_ref = 1'b1;
        bus.address == 4'hF:  wr_ctl = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- channel state ----------------
  logic [7:0] pixel_q  [CHANNELS];
  logic [7:0] prev_q   [CHANNELS];
  logic [7:0] thresh_q [CHANNELS];
  logic [7:0] count_q  [CHANNELS];
  logic [7:0] refrac_q [CHANNELS];
  logic [7:0] diff     [CHANNELS];
  logic [CHANNELS-1:0] eval_q;
  logic [CHANNELS-1:0] fire;
  logic [7:0] refrac_reg_q;
  logic [3:0] spike_q;
  logic [1:0] fire_ch;

  always_comb begin
    fire = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      diff[c] = (pixel_q[c] >= prev_q[c])
              ? pixel_q[c] - prev_q[c]
              : prev_q[c] - pixel_q[c];
      fire[c] = eval_q[c]
             && (diff[c] >= thresh_q[c])
             && (thresh_q[c] != 8'd0)
             && (refrac_q[c] == 8'd0);
    end
  end

  // Only one sample per cycle, so at most one bit of fire is set.
  always_comb begin
    fire_ch = 2'd0;
    for (int c = 0; c < CHANNELS; c++)
      if (fire[c]) fire_ch = 2'(c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_q       <= '0;
      spike_q      <= '0;
      refrac_reg_q <= 8'(REFRAC_DEFAULT);
      for (int c = 0; c < CHANNELS; c++) begin
        pixel_q[c]  <= '0;
        prev_q[c]   <= '0;
        thresh_q[c] <= 8'(THRESH_DEFAULT);
        count_q[c]  <= '0;
        refrac_q[c] <= '0;
      end
    end else begin
      spike_q <= 4'(fire);
      if (wr_ref) refrac_reg_q <= bus.data_in;
      for (int c = 0; c < CHANNELS; c++) begin
        eval_q[c] <= wr_pix && ch_sel[c];
        if (wr_pix && ch_sel[c]) begin
          prev_q[c]  <= pixel_q[c];
          pixel_q[c] <= bus.data_in;
        end
        if (wr_thr && ch_sel[c])
          thresh_q[c] <= bus.data_in;
        // clear beats a coincident spike
        if (wr_cnt && ch_sel[c])
          count_q[c] <= '0;
        else if (fire[c] && count_q[c] != 8'hFF)
          count_q[c] <= count_q[c] + 8'd1;
        if (fire[c])
          refrac_q[c] <= refrac_reg_q;
        else if (refrac_q[c] != 8'd0)
          refrac_q[c] <= refrac_q[c] - 8'd1;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [7:0]    entry;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, nonempty;
  logic          push, pop, push_ok;

`ifdef SPIKE_TIMESTAMP_EN
  logic [5:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 6'd1;
  end

  assign entry = {ts_q, fire_ch};
`else
  assign entry = {6'b0, fire_ch};
`endif

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign nonempty = (level_q != '0);
  assign push     = |fire;
  assign pop      = wr_pop && nonempty;
  // a pop frees the slot the same-cycle push lands in
  assign push_ok  = push && (!full || pop);

  always_comb begin
    level_d = level_q
            + {{(LW-1){1'b0}}, push_ok}
            - {{(LW-1){1'b0}}, pop};
    ovf_d = ovf_q;
    if (wr_ctl && bus.data_in[5]) ovf_d = 1'b0;
    if (push && !push_ok)         ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= entry;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // ---------------- outputs ----------------
  logic [7:0] head;
  logic [7:0] rdata;

  assign head = nonempty ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    rdata = '0;
    unique case (fn)
      2'd0: begin
        for (int c = 0; c < CHANNELS; c++)
          if (ch_sel[c]) rdata = pixel_q[c];
      end
      2'd1: begin
        for (int c = 0; c < CHANNELS; c++)
          if (ch_sel[c]) rdata = thresh_q[c];
      end
      2'd2: begin
        for (int c = 0; c < CHANNELS; c++)
          if (ch_sel[c]) rdata = count_q[c];
      end
      default: begin
        unique case (ch)
          2'd0:    rdata = head;
          2'd1:    rdata = {2'b00, ovf_q, nonempty,
                            4'(level_q)};
          2'd2:    rdata = refrac_reg_q;
          default: rdata = '0;
        endcase
      end
    endcase
  end

  assign bus.data_out = rdata;
  assign uo_out = {2'b00, ovf_q, nonempty, spike_q};

endmodule

// File: tb/tb_spike_edge_array.sv
// tb_spike_edge_array: scoreboard bench for spike_edge_array.
// FIFO entries are queued at stimulus time and checked on read.
module tb_spike_edge_array;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  spike_edge_array_if bus();

  spike_edge_array #(
    .CHANNELS(4),
    .FIFO_DEPTH(4),
    .REFRAC_DEFAULT(3),
    .THRESH_DEFAULT(20)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ui_in (ui_in),
    .uo_out(uo_out),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] tb_cyc;

  // reference time base for timestamped entries
  always @(posedge clk or posedge rst)
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;

  function automatic logic [7:0] mk_entry(
    input logic [5:0] ts, input logic [1:0] c);
`ifdef SPIKE_TIMESTAMP_EN
    return {ts, c};
`else
    return {ts & 6'h00, c};
`endif
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.data_in    = d;
    bus.data_write = 1'b1;
    @(negedge clk);
    bus.data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.data_write = 1'b0;
    #1 d = bus.data_out;
  endtask

  // sample a pixel, return uo_out in the spike cycle and the
  // timestamp an entry would carry
  task automatic pix(input logic [1:0] c, input logic [7:0] d,
                     output logic [7:0] uo, output logic [5:0] ts);
    @(negedge clk);
    bus.address    = {2'b00, c};
    bus.data_in    = d;
    bus.data_write = 1'b1;
    @(negedge clk);
    bus.data_write = 1'b0;
    ts = tb_cyc[5:0];
    @(negedge clk);
    uo = uo_out;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    ntests++;
    if (uo_out !== 8'h00) begin
      nfail++; $display("FAIL reset_uo: got %h want 00", uo_out);
    end
    rd(4'hD, d); ntests++;
    if (d !== 8'h00) begin
      nfail++; $display("FAIL reset_status: got %h want 00", d);
    end
    rd(4'h4, d); ntests++;
    if (d !== 8'd20) begin
      nfail++; $display("FAIL reset_thresh: got %h want 14", d);
    end
    rd(4'hE, d); ntests++;
    if (d !== 8'd3) begin
      nfail++; $display("FAIL reset_refrac: got %h want 03", d);
    end
    rd(4'h0, d); ntests++;
    if (d !== 8'h00) begin
      nfail++; $display("FAIL reset_pixel: got %h want 00", d);
    end
    rd(4'hC, d); ntests++;
    if (d !== 8'h00) begin
      nfail++; $display("FAIL reset_head: got %h want 00", d);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d, e;
    do_reset();
    wr(4'h0, 8'd30);
    exp_q.push_back(mk_entry(tb_cyc[5:0], 2'd0));
    ntests++;
    if (uo_out[0] !== 1'b0) begin
      nfail++; $display("FAIL basic_early: got %b want 0", uo_out[0]);
    end
    @(negedge clk); ntests++;
    if (uo_out[3:0] !== 4'b0001) begin
      nfail++; $display("FAIL basic_pulse: got %b want 0001", uo_out[3:0]);
    end
    @(negedge clk); ntests++;
    if (uo_out[0] !== 1'b0) begin
      nfail++; $display("FAIL basic_width: got %b want 0", uo_out[0]);
    end
    rd(4'h8, d); ntests++;
    if (d !== 8'd1) begin
      nfail++; $display("FAIL basic_count: got %h want 01", d);
    end
    rd(4'hD, d); ntests++;
    if (d !== 8'h11) begin
      nfail++; $display("FAIL basic_status: got %h want 11", d);
    end
    rd(4'hC, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    ntests++;
    if (d !== e) begin
      nfail++; $display("FAIL basic_head: got %h want %h", d, e);
    end
    wr(4'hC, 8'h00);
    rd(4'hD, d); ntests++;
    if (d !== 8'h00) begin
      nfail++; $display("FAIL basic_pop: got %h want 00", d);
    end
  endtask

  task automatic test_threshold();
    logic [7:0] d, e, uo;
    logic [5:0] ts;
    do_reset();
    wr(4'hE, 8'd0);
    wr(4'h6, 8'd50);
    rd(4'h6, d); ntests++;
    if (d !== 8'd50) begin
      nfail++; $display("FAIL thr_rw: got %h want 32", d);
    end
    pix(2'd2, 8'd100, uo, ts);
    exp_q.push_back(mk_entry(ts, 2'd2));
    ntests++;
    if (uo[3:0] !== 4'b0100) begin
      nfail++; $display("FAIL thr_first: got %b want 0100", uo[3:0]);
    end
    pix(2'd2, 8'd140, uo, ts); ntests++;
    if (uo[3:0] !== 4'b0000) begin
      nfail++; $display("FAIL thr_below: got %b want 0000", uo[3:0]);
    end
    pix(2'd2, 8'd200, uo, ts);
    exp_q.push_back(mk_entry(ts, 2'd2));
    ntests++;
    if (uo[3:0] !== 4'b0100) begin
      nfail++; $display("FAIL thr_above: got %b want 0100", uo[3:0]);
    end
    for (int i = 0; i < 2; i++) begin
      rd(4'hC, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      ntests++;
      if (d !== e) begin
        nfail++; $display("FAIL thr_head%0d: got %h want %h", i, d, e);
      end
      wr(4'hC, 8'h00);
    end
    rd(4'hD, d); ntests++;
    if (d !== 8'h00) begin
      nfail++; $display("FAIL thr_status: got %h want 00", d);
    end
  endtask

  task automatic test_refractory();
    logic [7:0] d, uo;
    logic [5:0] ts;
    do_reset();
    wr(4'hE, 8'd5);
    wr(4'h5, 8'd10);
    pix(2'd1, 8'd0, uo, ts); ntests++;
    if (uo[1] !== 1'b0) begin
      nfail++; $display("FAIL ref_zero: got %b want 0", uo[1]);
    end
    pix(2'd1, 8'd100, uo, ts); ntests++;
    if (uo[1] !== 1'b1) begin
      nfail++; $display("FAIL ref_spike1: got %b want 1", uo[1]);
    end
    pix(2'd1, 8'd0, uo, ts); ntests++;
    if (uo[1] !== 1'b0) begin
      nfail++; $display("FAIL ref_blocked: got %b want 0", uo[1]);
    end
    repeat (6) @(negedge clk);
    pix(2'd1, 8'd100, uo, ts); ntests++;
    if (uo[1] !== 1'b1) begin
      nfail++; $display("FAIL ref_spike2: got %b want 1", uo[1]);
    end
    rd(4'h9, d); ntests++;
    if (d !== 8'd2) begin
      nfail++; $display("FAIL ref_count: got %h want 02", d);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d, uo;
    logic [5:0] ts;
    do_reset();
    wr(4'hE, 8'd0);
    for (int i = 0; i < 5; i++) begin
      pix(2'd0, (i % 2 == 0) ? 8'd100 : 8'd0, uo, ts);
      if (i < 4) exp_q.push_back(mk_entry(ts, 2'd0));
    end
    rd(4'hD, d); ntests++;
    if (d !== 8'h34) begin
      nfail++; $display("FAIL ovf_status: got %h want 34", d);
    end
    ntests++;
    if (uo_out[5:4] !== 2'b11) begin
      nfail++; $display("FAIL ovf_uo: got %b want 11", uo_out[5:4]);
    end
    wr(4'hF, 8'h20);
    rd(4'hD, d); ntests++;
    if (d !== 8'h14) begin
      nfail++; $display("FAIL ovf_clear: got %h want 14", d);
    end
  endtask

  // relies on the full FIFO left by test_overflow
  task automatic test_back_to_back();
    logic [7:0] d, e, uo;
    logic [5:0] ts;
    @(negedge clk);
    bus.address    = 4'h1;
    bus.data_in    = 8'd100;
    bus.data_write = 1'b1;
    @(negedge clk);
    ts = tb_cyc[5:0];
    bus.address    = 4'hC;
    bus.data_write = 1'b1;
    #1 d = bus.data_out;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    exp_q.push_back(mk_entry(ts, 2'd1));
    ntests++;
    if (d !== e) begin
      nfail++; $display("FAIL b2b_head: got %h want %h", d, e);
    end
    @(negedge clk);
    bus.data_write = 1'b0;
    ntests++;
    if (uo_out[1] !== 1'b1) begin
      nfail++; $display("FAIL b2b_spike: got %b want 1", uo_out[1]);
    end
    rd(4'hD, d); ntests++;
    if (d !== 8'h14) begin
      nfail++; $display("FAIL b2b_level: got %h want 14", d);
    end
    for (int i = 0; i < 4; i++) begin
      rd(4'hC, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      ntests++;
      if (d !== e) begin
        nfail++; $display("FAIL b2b_drain%0d: got %h want %h", i, d, e);
      end
      wr(4'hC, 8'h00);
    end
    rd(4'hD, d); ntests++;
    if (d !== 8'h00) begin
      nfail++; $display("FAIL b2b_empty: got %h want 00", d);
    end
    pix(2'd0, 8'd0, uo, ts);
  endtask

  task automatic test_saturate();
    logic [7:0] d, uo;
    logic [5:0] ts;
    wr(4'hE, 8'd0);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      bus.address    = 4'h3;
      bus.data_in    = (i % 2 == 0) ? 8'd255 : 8'd0;
      bus.data_write = 1'b1;
    end
    @(negedge clk);
    bus.data_write = 1'b0;
    repeat (2) @(negedge clk);
    rd(4'hB, d); ntests++;
    if (d !== 8'd255) begin
      nfail++; $display("FAIL sat_255: got %h want ff", d);
    end
    pix(2'd3, 8'd0, uo, ts); ntests++;
    if (uo[3] !== 1'b1) begin
      nfail++; $display("FAIL sat_spike: got %b want 1", uo[3]);
    end
    rd(4'hB, d); ntests++;
    if (d !== 8'd255) begin
      nfail++; $display("FAIL sat_hold: got %h want ff", d);
    end
    @(negedge clk);
    bus.address    = 4'h3;
    bus.data_in    = 8'd255;
    bus.data_write = 1'b1;
    @(negedge clk);
    bus.address    = 4'hB;
    bus.data_in    = 8'h00;
    @(negedge clk);
    bus.data_write = 1'b0;
    ntests++;
    if (uo_out[3] !== 1'b1) begin
      nfail++; $display("FAIL clr_spike: got %b want 1", uo_out[3]);
    end
    rd(4'hB, d); ntests++;
    if (d !== 8'd0) begin
      nfail++; $display("FAIL clr_wins: got %h want 00", d);
    end
    pix(2'd3, 8'd0, uo, ts);
    rd(4'hB, d); ntests++;
    if (d !== 8'd1) begin
      nfail++; $display("FAIL clr_resume: got %h want 01", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, e, uo;
    logic [5:0] ts;
    @(negedge clk);
    bus.address    = 4'h0;
    bus.data_in    = 8'd200;
    bus.data_write = 1'b1;
    @(negedge clk);
    bus.data_write = 1'b0;
    rst = 1'b1;
    #1 ntests++;
    if (uo_out !== 8'h00) begin
      nfail++; $display("FAIL mid_uo: got %h want 00", uo_out);
    end
    rd(4'hD, d); ntests++;
    if (d !== 8'h00) begin
      nfail++; $display("FAIL mid_status: got %h want 00", d);
    end
    rd(4'h0, d); ntests++;
    if (d !== 8'h00) begin
      nfail++; $display("FAIL mid_pixel: got %h want 00", d);
    end
    rd(4'h4, d); ntests++;
    if (d !== 8'd20) begin
      nfail++; $display("FAIL mid_thresh: got %h want 14", d);
    end
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    ntests++;
    if (uo_out !== 8'h00) begin
      nfail++; $display("FAIL mid_noeval: got %h want 00", uo_out);
    end
    pix(2'd3, 8'd50, uo, ts);
    exp_q.push_back(mk_entry(ts, 2'd3));
    rd(4'hC, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    ntests++;
    if (d !== e) begin
      nfail++; $display("FAIL mid_entry: got %h want %h", d, e);
    end
  endtask

  initial begin
    rst            = 1'b1;
    ui_in          = 8'h00;
    bus.address    = 4'h0;
    bus.data_in    = 8'h00;
    bus.data_write = 1'b0;
    test_reset();
    test_basic();
    test_threshold();
    test_refractory();
    test_overflow();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
